// File: rtl/axi_lite_arbiter_2m.sv
// Two-master AXI-lite arbiter: M0 (fetch, read-only) and M1 (load/store) share one AXI-lite port.
// One transaction is in flight at a time; contention is resolved round-robin.
module axi_lite_arbiter_2m #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // M0: instruction fetch
  input  logic                    m0_rreq_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  output logic                    m0_done_o,
  // M1: load/store
  input  logic                    m1_rreq_i,
  input  logic                    m1_wreq_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask_i,
  output logic                    m1_done_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  // AXI-lite write address / data / response
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  // AXI-lite read address / data
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic                    r_valid_i,
  output logic                    r_ready_o
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StAr, StR, StWr, StB, StAck} state_e;

  state_e                  state_q, state_d;
  logic                    id_q, id_d;      // 0: M0, 1: M1
  logic                    last_q, last_d;  // requester granted most recently
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]    wstrb_q, wstrb_d;
  logic                    aw_pend_q, aw_pend_d;
  logic                    w_pend_q, w_pend_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic m0_req, m1_req, grant_m1;

  assign m0_req   = m0_rreq_i;
  assign m1_req   = m1_rreq_i | m1_wreq_i;
  // M1 wins only when M0 is idle or M0 held the previous grant.
  assign grant_m1 = m1_req & (~m0_req | ~last_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      id_q      <= id_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          id_d   = grant_m1;
          last_d = grant_m1;
          addr_d = grant_m1 ? m1_addr_i : m0_addr_i;
          // A simultaneous read+write request from M1 is served as a write.
          if (grant_m1 && m1_wreq_i) begin
            wdata_d   = m1_wdata_i;
            wstrb_d   = m1_wmask_i;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = StWr;
          end else begin
            wdata_d = '0;
            wstrb_d = '0;
            state_d = StAr;
          end
        end
      end
      StAr: begin
        if (ar_ready_i) state_d = StR;
      end
      StR: begin
        if (r_valid_i) begin
          rdata_d = r_data_i;
          state_d = StAck;
        end
      end
      StWr: begin
        aw_pend_d = aw_pend_q & ~aw_ready_i;
        w_pend_d  = w_pend_q & ~w_ready_i;
        if (!aw_pend_d && !w_pend_d) state_d = StB;
      end
      StB: begin
        if (b_valid_i) state_d = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ar_valid_o = (state_q == StAr);
    aw_valid_o = (state_q == StWr) && aw_pend_q;
    w_valid_o  = (state_q == StWr) && w_pend_q;
    r_ready_o  = (state_q == StR);
    b_ready_o  = (state_q == StB);
    m0_done_o  = (state_q == StAck) && !id_q;
    m1_done_o  = (state_q == StAck) && id_q;
    ar_addr_o  = ar_valid_o ? addr_q : '0;
    aw_addr_o  = aw_valid_o ? addr_q : '0;
    w_data_o   = w_valid_o ? wdata_q : '0;
    w_strb_o   = w_valid_o ? wstrb_q : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_axi_lite_arbiter_2m.sv
// Bench for axi_lite_arbiter_2m: AXI-lite slave model with programmable ready delays and a
// scoreboard of expected DONE events (requester ID and RDATA).
module tb_axi_lite_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_rreq, m1_rreq, m1_wreq;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [SW-1:0] m1_wmask;
  logic          m0_done, m1_done;
  logic [DW-1:0] rdata;
  logic [AW-1:0] aw_addr, ar_addr;
  logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [DW-1:0] w_data, r_data;
  logic [SW-1:0] w_strb;
  logic          ar_valid, ar_ready, r_valid, r_ready;

  axi_lite_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_rreq_i(m0_rreq), .m0_addr_i(m0_addr), .m0_done_o(m0_done),
    .m1_rreq_i(m1_rreq), .m1_wreq_i(m1_wreq), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_wmask_i(m1_wmask), .m1_done_o(m1_done),
    .rdata_o(rdata),
    .aw_addr_o(aw_addr), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .w_data_o(w_data), .w_strb_o(w_strb), .w_valid_o(w_valid), .w_ready_i(w_ready),
    .b_valid_i(b_valid), .b_ready_o(b_ready),
    .ar_addr_o(ar_addr), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .r_data_i(r_data), .r_valid_i(r_valid), .r_ready_o(r_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          id;
    logic          wr;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] exp_last_rd;
  int            n_checks = 0;
  int            n_fail = 0;
  int            ar_cyc = 0;
  int            aw_hs_cnt = 0;

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  // Slave model
  int            ar_dly = 0, aw_dly = 0, w_dly = 0;
  int            ar_cnt, aw_cnt, w_cnt;
  logic          r_stall = 1'b0;
  logic          rv_q, bv_q, aw_got, w_got;
  logic [DW-1:0] rd_q, wr_data_q;
  logic [AW-1:0] wr_addr_q;
  logic [SW-1:0] wr_strb_q;
  wire           aw_hs = aw_valid && aw_ready;
  wire           w_hs = w_valid && w_ready;

  assign ar_ready = ar_valid && (ar_cnt >= ar_dly);
  assign aw_ready = aw_valid && (aw_cnt >= aw_dly);
  assign w_ready  = w_valid && (w_cnt >= w_dly);
  assign r_valid  = rv_q && !r_stall;
  assign r_data   = rd_q;
  assign b_valid  = bv_q;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
        rv_q <= 1'b0; bv_q <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        rd_q <= '0; wr_addr_q <= '0; wr_data_q <= '0; wr_strb_q <= '0;
      end else begin
        ar_cnt <= (ar_valid && !ar_ready) ? ar_cnt + 1 : 0;
        aw_cnt <= (aw_valid && !aw_ready) ? aw_cnt + 1 : 0;
        w_cnt  <= (w_valid && !w_ready) ? w_cnt + 1 : 0;
        if (ar_valid && ar_ready) begin
          rv_q <= 1'b1;
          rd_q <= rd_model(ar_addr);
        end else if (r_valid && r_ready) begin
          rv_q <= 1'b0;
        end
        if (aw_hs) wr_addr_q <= aw_addr;
        if (w_hs) begin
          wr_data_q <= w_data;
          wr_strb_q <= w_strb;
        end
        if (bv_q && b_ready) bv_q <= 1'b0;
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          bv_q   <= 1'b1;
          aw_got <= 1'b0;
          w_got  <= 1'b0;
        end else begin
          if (aw_hs) aw_got <= 1'b1;
          if (w_hs) w_got <= 1'b1;
        end
      end
    end
  end

  // Scoreboard: every DONE pops the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ar_valid) ar_cyc++;
        if (aw_hs) aw_hs_cnt++;
        if (m0_done || m1_done) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_done: m0_done=%0b m1_done=%0b, required no DONE",
                     m0_done, m1_done);
          end else begin
            mon_e = exp_q.pop_front();
            if ({m0_done, m1_done} !== {!mon_e.id, mon_e.id}) begin
              n_fail++;
              $display("FAIL sb_done_id: {m0,m1}=%b required %b", {m0_done, m1_done},
                       {!mon_e.id, mon_e.id});
            end
            n_checks++;
            if (rdata !== mon_e.rdata) begin
              n_fail++;
              $display("FAIL sb_rdata: got %h required %h (wr=%0b)", rdata, mon_e.rdata,
                       mon_e.wr);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({ar_valid, aw_valid, w_valid, r_ready, b_ready, m0_done, m1_done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {ar_valid, aw_valid, w_valid, r_ready, b_ready, m0_done, m1_done});
    end
    n_checks++;
    if ({ar_addr, aw_addr, w_data, w_strb} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: ar=%h aw=%h w=%h s=%h required all 0", ar_addr, aw_addr,
               w_data, w_strb);
    end
    n_checks++;
    if (rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h required 0", rdata);
    end
    tick();
    rst = 1'b0;
    exp_last_rd = '0;
  endtask

  task automatic test_read_latency();
    tick();
    m0_rreq = 1'b1;
    m0_addr = 32'h8000_0000;
    exp_last_rd = 64'h1122_3344_5566_7788;
    exp_q.push_back('{id: 1'b0, wr: 1'b0, rdata: exp_last_rd});
    @(negedge clk);
    n_checks++;
    if (ar_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_c0_ar_valid: got %b required 0", ar_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({ar_valid, ar_addr} !== {1'b1, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL rd_c1_ar: valid=%b addr=%h required 1 80000000", ar_valid, ar_addr);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({r_ready, ar_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rd_c2_r_ready: {r_ready,ar_valid}=%b required 10", {r_ready, ar_valid});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({m0_done, m1_done, rdata} !== {2'b10, 64'h1122_3344_5566_7788}) begin
      n_fail++;
      $display("FAIL rd_c3_done: m0=%b m1=%b rdata=%h required 1 0 1122334455667788",
               m0_done, m1_done, rdata);
    end
    tick();
    m0_rreq = 1'b0;
    m0_addr = '0;
    @(negedge clk);
    n_checks++;
    if (m0_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_c4_done_pulse: m0_done=%b required 0", m0_done);
    end
  endtask

  task automatic test_round_robin();
    int  m0_seen = 0;
    int  m1_seen = 0;
    logic prev = 1'b0;
    logic cur;
    rst = 1'b1;
    m0_rreq = 1'b1; m0_addr = 32'h0000_1000;
    m1_rreq = 1'b1; m1_addr = 32'h0000_2000;
    exp_q.push_back('{id: 1'b0, wr: 1'b0, rdata: rd_model(32'h0000_1000)});
    exp_q.push_back('{id: 1'b1, wr: 1'b0, rdata: rd_model(32'h0000_2000)});
    exp_q.push_back('{id: 1'b0, wr: 1'b0, rdata: rd_model(32'h0000_1000)});
    exp_q.push_back('{id: 1'b1, wr: 1'b0, rdata: rd_model(32'h0000_2000)});
    exp_last_rd = rd_model(32'h0000_2000);
    tick();
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 60 && !(m0_seen == 2 && m1_seen == 2); cyc++) begin
      @(negedge clk);
      cur = m0_done | m1_done;
      if (cur) begin
        n_checks++;
        if (prev) begin
          n_fail++;
          $display("FAIL rr_done_width: DONE high two cycles running, required one");
        end
      end
      if (m0_done) m0_seen++;
      if (m1_done) m1_seen++;
      prev = cur;
      tick();
      if (m0_seen == 2) m0_rreq = 1'b0;
      if (m1_seen == 2) m1_rreq = 1'b0;
    end
    m0_rreq = 1'b0;
    m1_rreq = 1'b0;
    n_checks++;
    if ({m0_seen, m1_seen, exp_q.size()} !== {32'd2, 32'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL rr_count: m0=%0d m1=%0d pending=%0d required 2 2 0", m0_seen, m1_seen,
               exp_q.size());
    end
  endtask

  task automatic test_write_aw_delay();
    aw_dly = 3;
    tick();
    m1_wreq = 1'b1;
    m1_addr = 32'h8000_0010;
    m1_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    m1_wmask = 8'h0F;
    exp_q.push_back('{id: 1'b1, wr: 1'b1, rdata: exp_last_rd});
    @(negedge clk);
    n_checks++;
    if (aw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_c0_aw_valid: got %b required 0", aw_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({aw_valid, w_valid, aw_addr, w_data, w_strb} !==
        {2'b11, 32'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F}) begin
      n_fail++;
      $display("FAIL wr_c1_valids: aw=%b w=%b addr=%h data=%h strb=%h required 1 1 80000010 deadbeefcafef00d 0f",
               aw_valid, w_valid, aw_addr, w_data, w_strb);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({w_valid, w_data, aw_valid, aw_addr, b_ready} !==
          {1'b0, 64'h0, 1'b1, 32'h8000_0010, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_c%0d_aw_hold: w_valid=%b w_data=%h aw_valid=%b aw_addr=%h b_ready=%b required 0 0 1 80000010 0",
                 c, w_valid, w_data, aw_valid, aw_addr, b_ready);
      end
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({b_ready, aw_valid, aw_addr} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL wr_c5_b: b_ready=%b aw_valid=%b aw_addr=%h required 1 0 0", b_ready,
               aw_valid, aw_addr);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({m1_done, m0_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_c6_done: m1=%b m0=%b required 1 0", m1_done, m0_done);
    end
    tick();
    m1_wreq = 1'b0;
    aw_dly = 0;
    n_checks++;
    if ({wr_addr_q, wr_data_q, wr_strb_q} !==
        {32'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F}) begin
      n_fail++;
      $display("FAIL wr_slave_data: addr=%h data=%h strb=%h required 80000010 deadbeefcafef00d 0f",
               wr_addr_q, wr_data_q, wr_strb_q);
    end
  endtask

  task automatic test_rw_both();
    int ar_base;
    int aw_base;
    tick();
    m1_rreq = 1'b1;
    m1_wreq = 1'b1;
    m1_addr = 32'h0000_3000;
    m1_wdata = 64'h0123_4567_89AB_CDEF;
    m1_wmask = 8'hFF;
    exp_q.push_back('{id: 1'b1, wr: 1'b1, rdata: exp_last_rd});
    ar_base = ar_cyc;
    aw_base = aw_hs_cnt;
    for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      tick();
    end
    m1_rreq = 1'b0;
    m1_wreq = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rw_timeout: pending=%0d required 0", exp_q.size());
    end
    n_checks++;
    if ({ar_cyc - ar_base, aw_hs_cnt - aw_base} !== {32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL rw_as_write: ar_valid cycles=%0d aw handshakes=%0d required 0 1",
               ar_cyc - ar_base, aw_hs_cnt - aw_base);
    end
    n_checks++;
    if ({wr_addr_q, wr_data_q, wr_strb_q} !==
        {32'h0000_3000, 64'h0123_4567_89AB_CDEF, 8'hFF}) begin
      n_fail++;
      $display("FAIL rw_slave_data: addr=%h data=%h strb=%h required 00003000 0123456789abcdef ff",
               wr_addr_q, wr_data_q, wr_strb_q);
    end
  endtask

  task automatic test_reset_mid();
    r_stall = 1'b1;
    tick();
    m0_rreq = 1'b1;
    m0_addr = 32'h0000_4000;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (r_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_in_r: r_ready=%b required 1", r_ready);
    end
    tick();
    rst = 1'b1;
    m0_rreq = 1'b0;
    m0_addr = '0;
    tick();
    rst = 1'b0;
    r_stall = 1'b0;
    exp_last_rd = '0;
    @(negedge clk);
    n_checks++;
    if ({ar_valid, aw_valid, w_valid, r_ready, b_ready, m0_done, m1_done, ar_addr, aw_addr,
         w_data, w_strb, rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: ctrl=%b ar=%h aw=%h w=%h s=%h rdata=%h required all 0",
               {ar_valid, aw_valid, w_valid, r_ready, b_ready, m0_done, m1_done}, ar_addr,
               aw_addr, w_data, w_strb, rdata);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({m0_done, m1_done, r_ready, ar_valid} !== 4'b0) begin
        n_fail++;
        $display("FAIL rst_mid_idle%0d: {m0,m1,r_ready,ar_valid}=%b required 0000", c,
                 {m0_done, m1_done, r_ready, ar_valid});
      end
    end
    tick();
    m1_rreq = 1'b1;
    m1_addr = 32'h0000_5000;
    exp_last_rd = rd_model(32'h0000_5000);
    exp_q.push_back('{id: 1'b1, wr: 1'b0, rdata: exp_last_rd});
    for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      tick();
    end
    m1_rreq = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_recover: pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_rreq = 1'b0; m0_addr = '0;
    m1_rreq = 1'b0; m1_wreq = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    exp_last_rd = '0;
    test_reset();
    test_read_latency();
    test_round_robin();
    test_write_aw_delay();
    test_rw_both();
    test_reset_mid();
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: pending=%0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_2m.md
AXI_LITE_ARBITER_2M -- requirements
Module: axi_lite_arbiter_2m

Interface
REQ-001 Parameters: ADDR_WIDTH, default 32, width of all address buses; DATA_WIDTH, default 64, width of all data buses; strobe width is DATA_WIDTH/8.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RESET  input  1  synchronous active-high reset.
REQ-005 M0_RREQ  input  1  instruction-fetch read request, level, held until M0_DONE.
REQ-006 M0_ADDR  input  ADDR_WIDTH  M0 read address, stable while M0_RREQ high.
REQ-007 M0_DONE  output  1  one-cycle pulse: M0 read complete, RDATA valid.
REQ-008 M1_RREQ  input  1  load/store read request, level, held until M1_DONE.
REQ-009 M1_WREQ  input  1  load/store write request, level, held until M1_DONE.
REQ-010 M1_ADDR  input  ADDR_WIDTH  M1 read or write address.
REQ-011 M1_WDATA  input  DATA_WIDTH  M1 write data.
REQ-012 M1_WMASK  input  DATA_WIDTH/8  M1 byte strobes.
REQ-013 M1_DONE  output  1  one-cycle pulse: M1 transaction complete; RDATA valid if it was a read.
REQ-014 RDATA  output  DATA_WIDTH  registered read data, shared by both requesters.
REQ-015 AW_ADDR, AW_VALID output; AW_READY input: AXI-lite write-address channel.
REQ-016 W_DATA, W_STRB, W_VALID output; W_READY input: AXI-lite write-data channel.
REQ-017 B_VALID input; B_READY output: write-response channel (response code ignored).
REQ-018 AR_ADDR, AR_VALID output; AR_READY input: read-address channel.
REQ-019 R_DATA, R_VALID input; R_READY output: read-data channel (response code ignored).

Function
REQ-020 FSM states IDLE, AR, R, WR, B, ACK; exactly one outstanding transaction at any time.
REQ-021 IDLE: M0 request = M0_RREQ; M1 request = M1_RREQ|M1_WREQ; if exactly one is pending it SHALL be granted; if both are pending, the requester not granted last SHALL win (round-robin).
REQ-022 On grant, the block SHALL latch requester ID, address, and (M1 write) data/strobe; requester inputs SHALL be ignored thereafter until IDLE.
REQ-023 M1_WREQ and M1_RREQ high together SHALL be treated as a write.
REQ-024 Grant to read -> AR; grant to write -> WR; grant SHALL be registered so AR_VALID/AW_VALID rise the cycle after the request is seen.
REQ-025 AR: AR_VALID=1, AR_ADDR=latched address; on AR_READY -> R.
REQ-026 R: R_READY=1; on R_VALID, R_DATA SHALL be captured into RDATA -> ACK.
REQ-027 WR: AW_VALID and W_VALID SHALL both assert on entry and each SHALL drop independently after its own handshake; -> B once both handshakes are done (same or different cycles).
REQ-028 B: B_READY=1; on B_VALID -> ACK.
REQ-029 ACK: exactly one of M0_DONE/M1_DONE SHALL be high for this single cycle per the latched ID -> IDLE; no grant SHALL be made in ACK.
REQ-030 Minimum read latency with a zero-wait slave: request cycle 0, AR handshake cycle 1, R handshake cycle 2, DONE cycle 3; minimum write latency: DONE cycle 3.
REQ-031 AXI outputs SHALL be stable while VALID is high and unaccepted; AW_ADDR/W_DATA/W_STRB/AR_ADDR SHALL be 0 when their VALID is low.
REQ-032 RDATA SHALL hold its last value until the next R capture; it is unchanged by writes.

Reset
REQ-033 RESET SHALL force, at the next edge: state IDLE, all VALID/READY outputs 0, DONE outputs 0, RDATA 0, all latched address/data 0, and last-grant = M1 (M0 wins the first contention); a reset mid-transaction SHALL abandon it with no DONE.

Verification
REQ-034 M0_RREQ, M0_ADDR=0x8000_0000, zero-wait slave returning 0x1122334455667788 -> AR_VALID cycle 1, R_READY cycle 2, M0_DONE and RDATA=0x1122334455667788 cycle 3.
REQ-035 M0 and M1 read both held continuously from reset -> grants M0, M1, M0, M1 in order; each DONE exactly one cycle.
REQ-036 M1 write, addr 0x8000_0010, mask 0x0F; AW_READY delayed 3 cycles, W_READY immediate -> W_VALID drops after 1 cycle, AW_VALID held with stable address, B entered only after AW handshake, one M1_DONE.
REQ-037 M1_RREQ and M1_WREQ both high -> write issued, AR_VALID never asserted.
REQ-038 RESET asserted while in R with R_VALID low -> next cycle all outputs 0, state IDLE, no DONE pulse; a later request is then served normally.
